n29_array_corr_sched: RTL



---
 rtl/n29_array_corr_sched.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/n29_array_corr_sched.sv
// Sequential correction scheduler for a 5x5 block of AN-coded (A = 29) words:
// one shared residue checker on input, one shared single-error decoder on the row/column crosspoints.

module barrett_n29 #(
    parameter int CW_W  = 14,
    parameter int MSG_W = 10,
    parameter int RES_W = 5
) (
    input  logic [CW_W-1:0]  cw,
    output logic [MSG_W-1:0] q,
    output logic [RES_W-1:0] r,
    output logic             error
);
    // m = floor(2^19 / 29); for 14-bit inputs the estimate is q or q-1.
    localparam int K = 19;
    localparam int M = (1 << K) / 29;

    logic [28:0]      prod;
    logic [MSG_W-1:0] q_est;
    logic [5:0]       rem_est;
    logic             fix;

    always_comb begin
        prod    = 29'(cw) * 29'(M);
        q_est   = MSG_W'(prod >> K);
        rem_est = 6'(cw - CW_W'(CW_W'(q_est) * CW_W'(29)));
        fix     = (rem_est >= 6'd29);
        q       = fix ? q_est + MSG_W'(1) : q_est;
        r       = RES_W'(fix ? rem_est - 6'd29 : rem_est);
        error   = (r != '0);
    end
endmodule

module an_decoder_n29 #(
    parameter int CW_W  = 14,
    parameter int MSG_W = 10,
    parameter int RES_W = 5
) (
    input  logic [CW_W-1:0]  quotient,
    input  logic [RES_W-1:0] residue,
    output logic [MSG_W-1:0] message
);
    // 2 is a primitive root mod 29, so +/-2^j (j < 14) covers each nonzero residue exactly once.
    function automatic logic [RES_W-1:0] pos_res(input int j);
        return RES_W'((1 << j) % 29);
    endfunction

    function automatic logic [RES_W-1:0] neg_res(input int j);
        return RES_W'(29 - ((1 << j) % 29));
    endfunction

    function automatic logic [CW_W-1:0] pos_adj(input int j);
        return CW_W'(((1 << j) - ((1 << j) % 29)) / 29);
    endfunction

    function automatic logic [CW_W-1:0] neg_adj(input int j);
        return CW_W'(((1 << j) + 29 - ((1 << j) % 29)) / 29);
    endfunction

    always_comb begin
        // NOTE: default first so every path assigns message and no latch is inferred.
        message = MSG_W'(quotient);
        for (int j = 0; j < CW_W; j++) begin
            if (residue == pos_res(j))
                message = MSG_W'(quotient - pos_adj(j));
            else if (residue == neg_res(j))
                message = MSG_W'(quotient + neg_adj(j));
        end
    end
endmodule

module n29_array_corr_sched #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int CW_W  = 14,
    parameter int MSG_W = 10,
    parameter int RES_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MSG_W-1:0] out_data,
    output logic [4:0]       out_idx,
    output logic             out_last,
    output logic [4:0]       corr_count,
    output logic             multi_hit,
    output logic             busy
);
    localparam int NWORDS = ROWS * COLS;
    localparam logic [4:0] LAST = 5'(NWORDS - 1);

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] SCAN  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state;
    logic [4:0]       idx;
    logic [ROWS-1:0]  er;
    logic [COLS-1:0]  ec;
    logic [4:0]       cc;
    logic             mh;

    logic [MSG_W-1:0] q_mem [NWORDS];
    logic [RES_W-1:0] r_mem [NWORDS];

    logic [MSG_W-1:0] bar_q;
    logic [RES_W-1:0] bar_r;
    logic             bar_error;
    logic [MSG_W-1:0] dec_msg;
    logic [2:0]       row_sel;
    logic [2:0]       col_sel;
    logic             load_hs;
    logic             hit;

    barrett_n29 #(.CW_W(CW_W), .MSG_W(MSG_W), .RES_W(RES_W)) u_barrett (
        .cw    (in_data),
        .q     (bar_q),
        .r     (bar_r),
        .error (bar_error)
    );

    an_decoder_n29 #(.CW_W(CW_W), .MSG_W(MSG_W), .RES_W(RES_W)) u_decoder (
        .quotient ({{(CW_W-MSG_W){1'b0}}, q_mem[idx]}),
        .residue  (r_mem[idx]),
        .message  (dec_msg)
    );

    always_comb begin
        row_sel = 3'(idx / 5'(COLS));
        col_sel = 3'(idx % 5'(COLS));
        load_hs = (state == LOAD) && in_valid;
        hit     = (state == SCAN) && er[row_sel] && ec[col_sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            idx   <= '0;
            er    <= '0;
            ec    <= '0;
            cc    <= '0;
            mh    <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    if (bar_error) begin
                        er[row_sel] <= 1'b1;
                        ec[col_sel] <= 1'b1;
                    end
                    if (idx == LAST) begin
                        state <= SCAN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        if (cc != 5'(NWORDS)) cc <= cc + 5'd1;
                        if (cc == 5'd1) mh <= 1'b1;
                    end
                    if (idx == LAST) begin
                        state <= DRAIN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                DRAIN: if (out_ready) begin
                    if (idx == LAST) begin
                        state <= LOAD;
                        idx   <= '0;
                        er    <= '0;
                        ec    <= '0;
                        cc    <= '0;
                        mh    <= 1'b0;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // NOTE: the word store has no reset; idx, state and flags guarantee nothing stale is ever read out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_hs) begin
                q_mem[idx] <= bar_q;
                r_mem[idx] <= bar_r;
            end else if (hit) begin
                q_mem[idx] <= dec_msg;
            end
        end
    end

    // Outputs are forced low while rst is asserted, before the state register has cleared.
    always_comb begin
        in_ready   = !rst && (state == LOAD);
        out_valid  = !rst && (state == DRAIN);
        out_data   = out_valid ? q_mem[idx] : '0;
        out_idx    = out_valid ? idx : '0;
        out_last   = out_valid && (idx == LAST);
        corr_count = rst ? '0 : cc;
        multi_hit  = !rst && mh;
        busy       = !rst && ((state == SCAN) || (state == DRAIN));
    end
endmodule
